// File: rtl/uio_pin_ctrl.sv
// rtl/uio_pin_ctrl.sv - runtime-configurable uio pin controller with blink and edge capture
module uio_pin_ctrl #(
    parameter int NPIN        = 8,
    parameter int DIV_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [2:0]      cfg_addr,
    input  logic [NPIN-1:0] cfg_data,
    input  logic [2:0]      rd_addr,
    output logic [NPIN-1:0] rd_data,
    input  logic [NPIN-1:0] uio_in,
    output logic [NPIN-1:0] uio_out,
    output logic [NPIN-1:0] uio_oe,
    output logic [NPIN-1:0] edge_flags,
    output logic            irq
);

    localparam int MINW = (NPIN < DIV_W) ? NPIN : DIV_W;

    localparam logic [2:0] ADDR_OE    = 3'd0;
    localparam logic [2:0] ADDR_OUT   = 3'd1;
    localparam logic [2:0] ADDR_BLINK = 3'd2;
    localparam logic [2:0] ADDR_DIV   = 3'd3;
    localparam logic [2:0] ADDR_CLR   = 3'd4;
    localparam logic [2:0] ADDR_IRQM  = 3'd5;

    logic [NPIN-1:0]  oe_q;
    logic [NPIN-1:0]  out_q;
    logic [NPIN-1:0]  blink_q;
    logic [NPIN-1:0]  irqm_q;
    logic [NPIN-1:0]  flags_q;
    logic [DIV_W-1:0] reload_q;
    logic [DIV_W-1:0] cnt_q;
    logic             phase_q;
    logic [NPIN-1:0]  sync_q [SYNC_STAGES];
    logic [NPIN-1:0]  prev_q;
    logic             irq_q;

    logic             wr;
    logic [DIV_W-1:0] reload_wdata;
    logic [NPIN-1:0]  clr_mask;
    logic [NPIN-1:0]  rise;

    assign cfg_ready    = ena;
    assign wr           = cfg_valid && cfg_ready;
    assign reload_wdata = DIV_W'(cfg_data[MINW-1:0]);
    assign clr_mask     = (wr && cfg_addr == ADDR_CLR) ? cfg_data : '0;
    assign rise         = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oe_q    <= '0;
            out_q   <= '0;
            blink_q <= '0;
            irqm_q  <= '0;
        end else if (wr) begin
            case (cfg_addr)
                ADDR_OE:    oe_q    <= cfg_data;
                ADDR_OUT:   out_q   <= cfg_data;
                ADDR_BLINK: blink_q <= cfg_data;
                ADDR_IRQM:  irqm_q  <= cfg_data;
                default: ;
            endcase
        end
    end

    // A divider write restarts the blink period from a known phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_q <= '1;
            cnt_q    <= '1;
            phase_q  <= 1'b0;
        end else if (wr && cfg_addr == ADDR_DIV) begin
            reload_q <= reload_wdata;
            cnt_q    <= reload_wdata;
            phase_q  <= 1'b0;
        end else if (ena) begin
            if (cnt_q == '0) begin
                cnt_q   <= reload_q;
                phase_q <= ~phase_q;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Synchroniser and capture keep running while ena is low so no edge is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            prev_q  <= '0;
            flags_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            sync_q[0] <= uio_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            prev_q  <= sync_q[SYNC_STAGES-1];
            flags_q <= (flags_q & ~clr_mask) | (rise & ~oe_q);
            irq_q   <= |(flags_q & irqm_q);
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            ADDR_OE:    rd_data = oe_q;
            ADDR_OUT:   rd_data = out_q;
            ADDR_BLINK: rd_data = blink_q;
            ADDR_DIV:   rd_data = NPIN'(reload_q[MINW-1:0]);
            ADDR_IRQM:  rd_data = irqm_q;
            default:    rd_data = '0;
        endcase
    end

    assign uio_oe     = oe_q & {NPIN{ena}};
    assign uio_out    = out_q ^ (blink_q & {NPIN{phase_q}});
    assign edge_flags = flags_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_uio_pin_ctrl.sv
// tb/tb_uio_pin_ctrl.sv - directed plus random bench for uio_pin_ctrl against a behavioural model
module tb_uio_pin_ctrl;

    localparam int NPIN = 8;
    localparam int S    = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ena;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [2:0]      cfg_addr;
    logic [NPIN-1:0] cfg_data;
    logic [2:0]      rd_addr;
    logic [NPIN-1:0] rd_data;
    logic [NPIN-1:0] uio_in;
    logic [NPIN-1:0] uio_out;
    logic [NPIN-1:0] uio_oe;
    logic [NPIN-1:0] edge_flags;
    logic            irq;

    uio_pin_ctrl #(.NPIN(NPIN), .DIV_W(8), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe),
        .edge_flags(edge_flags), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: register images, pad-input history, and enabled-cycle count since last divider load.
    logic [7:0] m_oe, m_out, m_blink, m_irqm, m_flags, m_reload;
    logic       m_irq;
    int         n_en;
    logic [7:0] hist [$];

    function automatic void model_reset();
        m_oe = 0; m_out = 0; m_blink = 0; m_irqm = 0; m_flags = 0;
        m_reload = 8'hFF; m_irq = 0; n_en = 0;
        hist = {};
        for (int i = 0; i < S + 1; i++) hist.push_back(8'h00);
    endfunction

    function automatic logic m_phase();
        return ((n_en / (int'(m_reload) + 1)) % 2) == 1;
    endfunction

    function automatic logic [7:0] m_rd(input logic [2:0] a);
        case (a)
            3'd0: return m_oe;
            3'd1: return m_out;
            3'd2: return m_blink;
            3'd3: return m_reload;
            3'd5: return m_irqm;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("uio_oe", uio_oe, m_oe & {8{ena}});
        check("uio_out", uio_out, m_out ^ (m_blink & {8{m_phase()}}));
        check("edge_flags", edge_flags, m_flags);
        check("irq", irq, m_irq);
        check("cfg_ready", cfg_ready, ena);
        check("rd_data", rd_data, m_rd(rd_addr));
    endtask

    task automatic step(input logic v, input logic [2:0] a, input logic [7:0] d);
        logic       wr;
        logic [7:0] rise, nflags;
        logic       nirq;
        int         l;
        cfg_valid = v; cfg_addr = a; cfg_data = d;
        rd_addr   = 3'($urandom_range(0, 7));
        wr   = v && ena;
        l    = hist.size();
        rise = hist[l-S] & ~hist[l-S-1];
        nflags = (m_flags & ~((wr && a == 3'd4) ? d : 8'h00)) | (rise & ~m_oe);
        nirq   = |(m_flags & m_irqm);
        if (wr) begin
            case (a)
                3'd0: m_oe = d;
                3'd1: m_out = d;
                3'd2: m_blink = d;
                3'd3: begin m_reload = d; n_en = 0; end
                3'd5: m_irqm = d;
                default: ;
            endcase
        end
        if (!(wr && a == 3'd3) && ena) n_en++;
        m_flags = nflags;
        m_irq   = nirq;
        hist.push_back(uio_in);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 3'd0, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; cfg_valid = 1'b0; cfg_addr = 3'd0; cfg_data = 8'h00;
        rd_addr = 3'd3; uio_in = 8'h00;
        model_reset();
        #12;
        check_all();
        check("reset_rd_div", rd_data, 8'hFF);
        rst_n = 1'b1;

        idle(10);
        rd_addr = 3'd3; #1;
        check("idle_rd_div", rd_data, 8'hFF);

        step(1'b1, 3'd0, 8'h0F);
        check("oe_next_cycle", uio_oe, 8'h0F);
        step(1'b1, 3'd1, 8'h05);
        check("out_next_cycle", uio_out, 8'h05);

        step(1'b1, 3'd3, 8'd3);
        step(1'b1, 3'd2, 8'h01);
        idle(12);
        step(1'b1, 3'd3, 8'd0);
        idle(4);

        uio_in = 8'h10; step(1'b0, 3'd0, 8'h00);
        uio_in = 8'h00; idle(2);
        check("flag4_after_3_edges", edge_flags[4], 1'b1);
        idle(1);
        uio_in = 8'h01; step(1'b0, 3'd0, 8'h00);
        uio_in = 8'h00; idle(3);
        check("output_pin_no_flag", edge_flags[0], 1'b0);

        step(1'b1, 3'd5, 8'h10);
        step(1'b0, 3'd0, 8'h00);
        check("irq_after_mask", irq, 1'b1);
        step(1'b1, 3'd4, 8'h10);
        step(1'b0, 3'd0, 8'h00);
        check("irq_cleared", irq, 1'b0);
        uio_in = 8'h10;
        idle(2);
        step(1'b1, 3'd4, 8'h10);
        check("set_beats_clear", edge_flags[4], 1'b1);
        uio_in = 8'h00;
        idle(2);

        step(1'b1, 3'd3, 8'd2);
        step(1'b1, 3'd2, 8'hFF);
        idle(3);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, 3'd1, 8'hAA);
        check("ena_low_oe", uio_oe, 8'h00);
        ena = 1'b1;
        idle(5);

        for (int i = 0; i < 400; i++) begin
            ena = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) uio_in = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                automatic logic [2:0] a = 3'($urandom_range(0, 7));
                automatic logic [7:0] d = 8'($urandom);
                if (a == 3'd3) d = d & 8'h07;
                step(1'b1, a, d);
            end else begin
                step(1'b0, 3'd0, 8'h00);
            end
        end

        ena = 1'b1;
        step(1'b1, 3'd0, 8'hF0);
        step(1'b1, 3'd1, 8'hFF);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        check("reset_mid_oe", uio_oe, 8'h00);
        check("reset_mid_out", uio_out, 8'h00);
        #2 rst_n = 1'b1;
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
